// File: rtl/encrypt_feeder.sv
// Feeder around a fixed-latency, non-stallable block cipher: input FIFO, credit-limited
// issue, in-flight tracking shift register and an output FIFO that can never overflow.
module encrypt_feeder #(
  parameter int N_B       = 16,
  parameter int N_K       = 16,
  parameter int LAT       = 9,
  parameter int IN_DEPTH  = 4,
  parameter int OUT_DEPTH = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N_K-1:0] in_k,
  input  logic [N_B-1:0] in_m,
  output logic [N_K-1:0] enc_k,
  output logic [N_B-1:0] enc_m,
  output logic           enc_issue,
  input  logic [N_B-1:0] enc_c,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [N_B-1:0] out_c,
  output logic           busy
);

  localparam int IAW = $clog2(IN_DEPTH);
  localparam int OAW = $clog2(OUT_DEPTH);
  localparam int ICW = IAW + 1;
  localparam int OCW = OAW + 1;

  logic [N_K-1:0] in_k_mem_q [IN_DEPTH];
  logic [N_B-1:0] in_m_mem_q [IN_DEPTH];
  logic [N_B-1:0] out_mem_q  [OUT_DEPTH];

  logic [IAW-1:0] in_wr_q, in_wr_d, in_rd_q, in_rd_d;
  logic [ICW-1:0] in_cnt_q, in_cnt_d;
  logic [OAW-1:0] out_wr_q, out_wr_d, out_rd_q, out_rd_d;
  logic [OCW-1:0] out_cnt_q, out_cnt_d;
  logic [OCW-1:0] inflight_q, inflight_d;
  logic [LAT-1:0] sr_q, sr_d;
  logic [N_K-1:0] enc_k_q, enc_k_d;
  logic [N_B-1:0] enc_m_q, enc_m_d;
  logic           enc_issue_q, enc_issue_d;
  logic [N_B-1:0] out_c_q, out_c_d;

  logic           push, issue, capture, out_pop, credit_ok;
  logic [OCW:0]   occupied;

  assign in_ready  = (in_cnt_q != ICW'(IN_DEPTH));
  assign out_valid = (out_cnt_q != '0);
  assign push      = in_valid && in_ready;
  assign out_pop   = out_valid && out_ready;
  assign capture   = sr_q[LAT-1];

  // Every block in flight or waiting downstream holds a reserved output slot.
  assign occupied  = {1'b0, out_cnt_q} + {1'b0, inflight_q};
  assign credit_ok = (occupied < (OCW + 1)'(OUT_DEPTH));
  assign issue     = (in_cnt_q != '0) && credit_ok;

  always_comb begin
    in_wr_d     = in_wr_q;
    in_rd_d     = in_rd_q;
    in_cnt_d    = in_cnt_q;
    enc_k_d     = enc_k_q;
    enc_m_d     = enc_m_q;
    enc_issue_d = issue;
    sr_d        = LAT'({sr_q, enc_issue_q});
    inflight_d  = inflight_q;

    if (push) in_wr_d = in_wr_q + IAW'(1);
    if (issue) begin
      in_rd_d = in_rd_q + IAW'(1);
      enc_k_d = in_k_mem_q[in_rd_q];
      enc_m_d = in_m_mem_q[in_rd_q];
    end
    case ({push, issue})
      2'b10:   in_cnt_d = in_cnt_q + ICW'(1);
      2'b01:   in_cnt_d = in_cnt_q - ICW'(1);
      default: in_cnt_d = in_cnt_q;
    endcase
    case ({issue, capture})
      2'b10:   inflight_d = inflight_q + OCW'(1);
      2'b01:   inflight_d = inflight_q - OCW'(1);
      default: inflight_d = inflight_q;
    endcase
  end

  always_comb begin
    out_wr_d  = out_wr_q;
    out_rd_d  = out_rd_q;
    out_cnt_d = out_cnt_q;
    out_c_d   = out_c_q;

    if (capture) out_wr_d = out_wr_q + OAW'(1);
    if (out_pop) out_rd_d = out_rd_q + OAW'(1);
    case ({capture, out_pop})
      2'b10:   out_cnt_d = out_cnt_q + OCW'(1);
      2'b01:   out_cnt_d = out_cnt_q - OCW'(1);
      default: out_cnt_d = out_cnt_q;
    endcase

    // Next head is the incoming ciphertext only when it lands in the head slot.
    if (capture && (out_wr_q == out_rd_d)) begin
      out_c_d = enc_c;
    end else if (out_cnt_d != '0) begin
      out_c_d = out_mem_q[out_rd_d];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_wr_q     <= '0;
      in_rd_q     <= '0;
      in_cnt_q    <= '0;
      out_wr_q    <= '0;
      out_rd_q    <= '0;
      out_cnt_q   <= '0;
      inflight_q  <= '0;
      sr_q        <= '0;
      enc_k_q     <= '0;
      enc_m_q     <= '0;
      enc_issue_q <= 1'b0;
      out_c_q     <= '0;
    end else begin
      in_wr_q     <= in_wr_d;
      in_rd_q     <= in_rd_d;
      in_cnt_q    <= in_cnt_d;
      out_wr_q    <= out_wr_d;
      out_rd_q    <= out_rd_d;
      out_cnt_q   <= out_cnt_d;
      inflight_q  <= inflight_d;
      sr_q        <= sr_d;
      enc_k_q     <= enc_k_d;
      enc_m_q     <= enc_m_d;
      enc_issue_q <= enc_issue_d;
      out_c_q     <= out_c_d;
    end
  end

  // FIFO storage carries data only; validity lives in the pointers and counts.
  always_ff @(posedge clk) begin
    if (push) begin
      in_k_mem_q[in_wr_q] <= in_k;
      in_m_mem_q[in_wr_q] <= in_m;
    end
    if (capture) out_mem_q[out_wr_q] <= enc_c;
  end

  assign enc_k     = enc_k_q;
  assign enc_m     = enc_m_q;
  assign enc_issue = enc_issue_q;
  assign out_c     = out_c_q;
  assign busy      = (in_cnt_q != '0) || (inflight_q != '0) || (out_cnt_q != '0);

endmodule

// File: tb/tb_encrypt_feeder.sv
// Bench for encrypt_feeder: XOR cipher model with LAT-cycle delay, scoreboard of
// expected ciphertexts filled on accepted pushes and drained on output pops.
module tb_encrypt_feeder;
  localparam int N_B = 16, N_K = 16, LAT = 9, IN_DEPTH = 4, OUT_DEPTH = 8;

  logic           clk = 1'b0;
  logic           rst_n = 1'b1;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [N_K-1:0] in_k = '0;
  logic [N_B-1:0] in_m = '0;
  logic [N_K-1:0] enc_k;
  logic [N_B-1:0] enc_m;
  logic           enc_issue;
  logic [N_B-1:0] enc_c;
  logic           out_valid;
  logic           out_ready = 1'b0;
  logic [N_B-1:0] out_c;
  logic           busy;

  always #5 clk = ~clk;

  encrypt_feeder #(.N_B(N_B), .N_K(N_K), .LAT(LAT), .IN_DEPTH(IN_DEPTH), .OUT_DEPTH(OUT_DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_k(in_k), .in_m(in_m),
    .enc_k(enc_k), .enc_m(enc_m), .enc_issue(enc_issue), .enc_c(enc_c),
    .out_valid(out_valid), .out_ready(out_ready), .out_c(out_c), .busy(busy)
  );

  // Cipher stand-in: no reset, so stale values keep flowing after a DUT reset.
  logic [N_B-1:0] pipe [LAT];
  initial for (int i = 0; i < LAT; i++) pipe[i] = '0;
  always @(posedge clk) begin
    pipe[0] <= enc_m ^ enc_k;
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign enc_c = pipe[LAT-1];

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [N_B-1:0] sb [$];
  int iss_cyc [$];
  int pop_cyc [$];
  int n_iss = 0;
  int n_pop = 0;

  // Handshakes seen here take effect on the following rising edge.
  always @(negedge clk) begin
    logic [N_B-1:0] exp_c;
    if (!rst_n) begin
      sb.delete();
      n_iss = 0;
      n_pop = 0;
    end else begin
      if (in_valid && in_ready) sb.push_back(in_m ^ in_k);
      if (enc_issue) begin
        n_iss++;
        iss_cyc.push_back(cyc);
        check("outstanding_le_depth", 32'((n_iss - n_pop) <= OUT_DEPTH), 32'd1);
      end
      if (out_valid && out_ready) begin
        n_pop++;
        pop_cyc.push_back(cyc);
        if (sb.size() == 0) begin
          check("out_unexpected", 32'(out_valid), 32'd0);
        end else begin
          exp_c = sb.pop_front();
          check("out_c", 32'(out_c), 32'(exp_c));
        end
      end
    end
  end

  task automatic push(input logic [N_K-1:0] k, input logic [N_B-1:0] m);
    int t;
    in_valid = 1'b1;
    in_k = k;
    in_m = m;
    t = 0;
    @(negedge clk);
    while (!in_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) check("push_timeout", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 300 && (busy || sb.size() != 0); i++) begin
      @(posedge clk); #1;
    end
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_sb_left"}, 32'(sb.size()), 32'd0);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_enc_m"}, 32'(enc_m), 32'd0);
    check({tag, "_enc_issue"}, 32'(enc_issue), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int iss_lat, out_lat, bi, bp, bad;

    // Asynchronous reset asserted between clock edges.
    #12 rst_n = 1'b0;
    #1 check_reset_state("rst0");
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // Single block latency.
    out_ready = 1'b1;
    push(16'h1234, 16'hABCD);
    in_valid = 1'b0;
    iss_lat = -1;
    out_lat = -1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (enc_issue && iss_lat < 0) iss_lat = i;
      if (out_valid) begin
        out_lat = i;
        break;
      end
    end
    check("single_issue_lat", 32'(iss_lat), 32'd1);
    check("single_out_lat", 32'(out_lat), 32'(LAT + 2));
    check("single_out_c", 32'(out_c), 32'h0000B9F9);
    wait_idle("single");

    // Stream of 20 blocks, downstream always ready.
    bi = iss_cyc.size();
    bp = pop_cyc.size();
    for (int k = 0; k < 20; k++) push(16'(k * 16'h0101) ^ 16'h5A5A, 16'h1000 + 16'(k * 37));
    in_valid = 1'b0;
    for (int i = 0; i < 300 && sb.size() != 0; i++) begin
      @(posedge clk); #1;
    end
    check("stream_sb_left", 32'(sb.size()), 32'd0);
    check("stream_busy_after_last_pop", 32'(busy), 32'd0);
    check("stream_issues", 32'(iss_cyc.size() - bi), 32'd20);
    check("stream_pops", 32'(pop_cyc.size() - bp), 32'd20);
    if (iss_cyc.size() - bi >= 8)
      check("stream_first8_issue_span", 32'(iss_cyc[bi+7] - iss_cyc[bi]), 32'd7);
    if (pop_cyc.size() - bp >= 8)
      check("stream_first8_pop_span", 32'(pop_cyc[bp+7] - pop_cyc[bp]), 32'd7);

    // Backpressure: credits run out after OUT_DEPTH issues, then input FIFO fills.
    out_ready = 1'b0;
    bi = iss_cyc.size();
    bp = pop_cyc.size();
    for (int k = 0; k < OUT_DEPTH + IN_DEPTH; k++) push(16'hC000 + 16'(k), 16'h7700 + 16'(k * 3));
    // Further offers with changing data must be refused.
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      in_m = 16'($urandom);
      @(negedge clk);
      if (in_ready) bad++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    check("bp_in_ready_cycles", 32'(bad), 32'd0);
    check("bp_in_ready_now", 32'(in_ready), 32'd0);
    check("bp_issues", 32'(iss_cyc.size() - bi), 32'(OUT_DEPTH));
    check("bp_out_valid", 32'(out_valid), 32'd1);
    check("bp_sb_held", 32'(sb.size()), 32'(OUT_DEPTH + IN_DEPTH));
    out_ready = 1'b1;
    wait_idle("bp");
    check("bp_pops", 32'(pop_cyc.size() - bp), 32'(OUT_DEPTH + IN_DEPTH));

    // Reset with blocks in flight; stale cipher outputs must be ignored.
    bp = pop_cyc.size();
    for (int k = 0; k < 3; k++) push(16'h0F0F, 16'h8421 + 16'(k));
    in_valid = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1 check_reset_state("rst_flight");
    @(posedge clk); #2;
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 2 * LAT; i++) begin
      @(posedge clk); #1;
      if (out_valid) bad++;
    end
    check("rst_flight_no_out", 32'(bad), 32'd0);
    check("rst_flight_pops", 32'(pop_cyc.size() - bp), 32'd0);
    push(16'h2468, 16'h1357);
    in_valid = 1'b0;
    wait_idle("post_rst");
    check("post_rst_pops", 32'(pop_cyc.size() - bp), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
